// File: rtl/riscv_structures.sv
// Shared pipeline-register types for the RISC-V core: EX->MEM and MEM->WB
// stage registers plus the memory-stage FSM state encoding.
package riscv_structures;

    localparam int XLEN = 32;

    typedef struct packed {
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            instr_done;
        logic            is_final;
        logic [4:0]      rd;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] mem_data;
    } ex_to_mem_s;

    typedef struct packed {
        logic            reg_write;
        logic [4:0]      rd;
        logic [XLEN-1:0] result;
        logic            instr_done;
        logic            is_final;
    } mem_to_wb_s;

    typedef enum logic {
        MEM_IDLE,
        MEM_WAIT_RESP
    } mem_state_e;

endpackage

// File: rtl/mem_stage.sv
// Memory stage: word loads/stores over a valid/ready data port, registered into mem_to_wb.
// Optional MEM_MISALIGN_CHECK_EN traps non-word-aligned accesses locally.
module mem_stage
    import riscv_structures::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  ex_to_mem_s        ex_to_mem,
    output logic              mem_busy,
    output logic [XLEN-1:0]   bp_mem,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_we,
    output logic [ADDR_W-1:0] dmem_req_addr,
    output logic [DATA_W-1:0] dmem_req_wdata,
    input  logic              dmem_resp_valid,
    input  logic [DATA_W-1:0] dmem_resp_rdata,
    output mem_to_wb_s        mem_to_wb
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic              misalign,
    output logic [ADDR_W-1:0] misalign_addr
`endif
);

    mem_state_e state_q, state_d;
    mem_to_wb_s wb_q, wb_d;
    logic       mem_op, access, mis, complete, use_rdata;

    assign mem_op = ex_to_mem.mem_read | ex_to_mem.mem_write;

`ifdef MEM_MISALIGN_CHECK_EN
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] misalign_addr_q, misalign_addr_d;

    assign mis    = mem_op & (ex_to_mem.alu_result[1:0] != 2'b00);
    assign access = mem_op & ~mis;
`else
    assign mis    = 1'b0;
    assign access = mem_op;
`endif

    assign bp_mem         = ex_to_mem.alu_result;
    assign dmem_req_we    = ex_to_mem.mem_write;
    assign dmem_req_addr  = ADDR_W'(ex_to_mem.alu_result);
    assign dmem_req_wdata = DATA_W'(ex_to_mem.mem_data);

    // Busy never depends on read data, only on the handshake/response strobes.
    always_comb begin
        state_d        = state_q;
        dmem_req_valid = 1'b0;
        mem_busy       = 1'b0;
        complete       = 1'b0;
        use_rdata      = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (access) begin
                    dmem_req_valid = 1'b1;
                    if (!dmem_req_ready) begin
                        mem_busy = 1'b1;
                    end else if (ex_to_mem.mem_write) begin
                        complete = 1'b1;
                    end else begin
                        state_d  = MEM_WAIT_RESP;
                        mem_busy = 1'b1;
                    end
                end else begin
                    complete = 1'b1;
                end
            end
            MEM_WAIT_RESP: begin
                if (dmem_resp_valid) begin
                    complete  = 1'b1;
                    use_rdata = 1'b1;
                    state_d   = MEM_IDLE;
                end else begin
                    mem_busy = 1'b1;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_comb begin
        wb_d = '0;
        if (complete) begin
            wb_d.reg_write  = ex_to_mem.reg_write & ~ex_to_mem.mem_write & ~mis;
            wb_d.rd         = ex_to_mem.rd;
            wb_d.result     = use_rdata ? XLEN'(dmem_resp_rdata) : ex_to_mem.alu_result;
            wb_d.instr_done = ex_to_mem.instr_done;
            wb_d.is_final   = ex_to_mem.is_final;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_IDLE;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
        end
    end

    assign mem_to_wb = wb_q;

`ifdef MEM_MISALIGN_CHECK_EN
    // Trap is a one-cycle pulse; the address is kept until the next trap.
    always_comb begin
        misalign_d      = (state_q == MEM_IDLE) & mis;
        misalign_addr_d = misalign_d ? ADDR_W'(ex_to_mem.alu_result) : misalign_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign misalign      = misalign_q;
    assign misalign_addr = misalign_addr_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a transaction-level model predicts busy
// cycles, request count and the written-back record for each instruction.
module tb_mem_stage;
    import riscv_structures::*;

    logic        clk = 1'b0;
    logic        rst;
    ex_to_mem_s  ex_to_mem;
    logic        mem_busy;
    logic [31:0] bp_mem;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [31:0] dmem_req_addr, dmem_req_wdata;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;
    mem_to_wb_s  mem_to_wb;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign;
    logic [31:0] misalign_addr;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .ex_to_mem(ex_to_mem),
        .mem_busy(mem_busy), .bp_mem(bp_mem),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wdata(dmem_req_wdata), .dmem_resp_valid(dmem_resp_valid),
        .dmem_resp_rdata(dmem_resp_rdata), .mem_to_wb(mem_to_wb)
`ifdef MEM_MISALIGN_CHECK_EN
        , .misalign(misalign), .misalign_addr(misalign_addr)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // kind: 0 = ALU op, 1 = store, 2 = load. d = ready-low cycles before accept,
    // lat = cycles from accept to the load response.
    task automatic run_instr(input int kind, input logic [4:0] rd, input logic rw,
                             input logic [31:0] alu, input logic [31:0] wdata,
                             input int d, input int lat, input logic [31:0] rdata,
                             input logic fin);
        ex_to_mem_s e;
        logic is_mem, mis, done;
        int   exp_busy, exp_reqs, busy_cnt, reqs, c;
        e = '0;
        e.mem_read   = (kind == 2);
        e.mem_write  = (kind == 1);
        e.reg_write  = rw;
        e.instr_done = 1'b1;
        e.is_final   = fin;
        e.rd         = rd;
        e.alu_result = alu;
        e.mem_data   = wdata;
        is_mem = (kind != 0);
`ifdef MEM_MISALIGN_CHECK_EN
        mis = is_mem && (alu[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        exp_busy = (!is_mem || mis) ? 0 : (kind == 1 ? d : d + lat);
        exp_reqs = (is_mem && !mis) ? 1 : 0;
        busy_cnt = 0; reqs = 0; c = 0; done = 1'b0;
        while (!done && c < 40) begin
            @(negedge clk);
            ex_to_mem       = e;
            dmem_req_ready  = is_mem ? (c >= d) : 1'($urandom_range(0, 1));
            dmem_resp_valid = (kind == 2 && !mis && c == d + lat) ||
                              (kind == 0 && $urandom_range(0, 3) == 0);
            dmem_resp_rdata = (kind == 2) ? rdata : $urandom;
            #1;
            chk("bypass", bp_mem, alu);
            if (dmem_req_valid) begin
                chk("req_addr", dmem_req_addr, alu);
                chk("req_we", dmem_req_we, kind == 1);
                if (kind == 1) chk("req_wdata", dmem_req_wdata, wdata);
                if (dmem_req_ready) reqs++;
            end
            if (mem_busy) busy_cnt++;
            else done = 1'b1;
            @(posedge clk); #1;
            if (!done) begin
                chk("bubble_done", mem_to_wb.instr_done, 0);
                chk("bubble_rw", mem_to_wb.reg_write, 0);
            end
            c++;
        end
        chk("completed", done, 1);
        chk("busy_cycles", busy_cnt, exp_busy);
        chk("req_count", reqs, exp_reqs);
        chk("wb_reg_write", mem_to_wb.reg_write, rw && kind != 1 && !mis);
        chk("wb_rd", mem_to_wb.rd, rd);
        chk("wb_result", mem_to_wb.result, (kind == 2 && !mis) ? rdata : alu);
        chk("wb_done", mem_to_wb.instr_done, 1);
        chk("wb_final", mem_to_wb.is_final, fin);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("misalign", misalign, mis);
        if (mis) chk("misalign_addr", misalign_addr, alu);
`endif
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ex_to_mem = '0;
        dmem_req_ready = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb", mem_to_wb, 0);
        chk("rst_busy", mem_busy, 0);
        chk("rst_req_valid", dmem_req_valid, 0);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("rst_misalign", misalign, 0);
`endif
        @(negedge clk); rst = 1'b0;

        run_instr(0, 5'd5, 1'b1, 32'h10, 32'h0, 0, 0, 32'h0, 1'b0);
        run_instr(1, 5'd7, 1'b1, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b0);
        run_instr(2, 5'd9, 1'b1, 32'h200, 32'h0, 0, 1, 32'h1234_5678, 1'b0);
        run_instr(2, 5'd11, 1'b1, 32'h204, 32'h0, 3, 2, 32'hCAFE_F00D, 1'b0);
        run_instr(2, 5'd12, 1'b1, 32'h208, 32'h0, 0, 1, 32'hA5A5_0001, 1'b0);
        run_instr(2, 5'd13, 1'b1, 32'h20C, 32'h0, 0, 1, 32'hA5A5_0002, 1'b1);
`ifdef MEM_MISALIGN_CHECK_EN
        run_instr(2, 5'd3, 1'b1, 32'h202, 32'h0, 0, 1, 32'h5555_5555, 1'b0);
`endif

        // Reset while waiting for a load response; a late response must be dropped.
        @(negedge clk);
        ex_to_mem = '0;
        ex_to_mem.mem_read = 1'b1; ex_to_mem.reg_write = 1'b1;
        ex_to_mem.rd = 5'd4; ex_to_mem.alu_result = 32'h300; ex_to_mem.instr_done = 1'b1;
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_wb", mem_to_wb, 0);
        @(negedge clk);
        rst = 1'b0;
        ex_to_mem = '0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'hBAD0_BAD0;
        #1;
        chk("midrst_busy", mem_busy, 0);
        chk("midrst_req", dmem_req_valid, 0);
        @(posedge clk); #1;
        chk("midrst_result", mem_to_wb.result, 0);
        chk("midrst_rw", mem_to_wb.reg_write, 0);
        dmem_resp_valid = 1'b0;

        for (int i = 0; i < 300; i++) begin
            int k;
            logic [31:0] a;
            k = $urandom_range(0, 2);
            a = $urandom;
            if (k != 0 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_instr(k, 5'($urandom), 1'($urandom), a, $urandom,
                      $urandom_range(0, 3), $urandom_range(1, 3), $urandom,
                      1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage RISC-V pipeline. Consumes `ex_to_mem_s` from execute, performs word loads and stores over a valid/ready data-memory port, and registers the result into `mem_to_wb_s` for writeback. It also drives the MEM-stage bypass value and a busy signal, which the hazard unit uses to stall upstream stages.

## Interface
- `ADDR_W`, 32, data-memory address width
- `DATA_W`, 32, data width; word accesses only

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `ex_to_mem`  in  `ex_to_mem_s`  execute-stage register: mem_read, mem_write, reg_write, instr_done, is_final, rd, alu_result (address/ALU value), mem_data (store data)
- `mem_busy`  out  1  high while an access is outstanding; the hazard unit deasserts upstream `enable` from it
- `bp_mem`  out  32  bypass value = `ex_to_mem.alu_result` (combinational)
- `dmem_req_valid`  out  1  request valid
- `dmem_req_ready`  in  1  memory accepts request
- `dmem_req_we`  out  1  1 = store
- `dmem_req_addr`  out  ADDR_W  = `ex_to_mem.alu_result`
- `dmem_req_wdata`  out  DATA_W  = `ex_to_mem.mem_data`
- `dmem_resp_valid`  in  1  load data valid (one-cycle pulse)
- `dmem_resp_rdata`  in  DATA_W  load data
- `mem_to_wb`  out  `mem_to_wb_s`  registered: reg_write, rd, result, instr_done, is_final
- `misalign`, `misalign_addr`  out  1 / ADDR_W  only with `MEM_MISALIGN_CHECK_EN`

## Operation
- A memory operation is present when `mem_read || mem_write`. Otherwise the stage has pass-through behaviour: `result = alu_result`, with no busy.
- FSM states: IDLE and WAIT_RESP.
- IDLE, access present:
  - `dmem_req_valid` = 1 combinationally.
  - `dmem_req_we` = `mem_write`.
- IDLE, store, handshake (valid && ready): the store completes. `mem_busy` = 0 in that cycle and the state stays IDLE.
- IDLE, load, handshake: the state goes to WAIT_RESP and `mem_busy` = 1.
- IDLE, no handshake (ready low): the state stays IDLE and `mem_busy` = 1. The request holds stable, because the upstream stall keeps `ex_to_mem` constant.
- WAIT_RESP:
  - `dmem_req_valid` = 0.
  - `mem_busy` = 1 until `dmem_resp_valid`.
  - In the response cycle, `mem_busy` = 0 and the state returns to IDLE.
- `mem_to_wb` update rule (every cycle):
  - If the instruction completes this cycle (non-memory, store accepted, or load response), the register captures rd, reg_write, instr_done and is_final.
  - `result` = `dmem_resp_rdata` for a load, otherwise `alu_result`.
  - If the instruction does not complete, a bubble is loaded: reg_write = 0, instr_done = 0, is_final = 0.
- `dmem_resp_valid` in IDLE is ignored.
- A store never writes a register; `reg_write` is forced to 0 when `mem_write`.

## Timing
- Reset values: state IDLE; all `mem_to_wb` fields 0; `dmem_req_valid` 0; `mem_busy` 0; `misalign` 0.
- Reset mid-access: the FSM returns to IDLE and any pending response is dropped. The memory side must also be reset.
- Latency with zero-wait memory (ready = 1, response one cycle after accept):
  - Non-memory and store: 1 cycle to `mem_to_wb`.
  - Load: 2 cycles, with `mem_busy` high for exactly 1 cycle.
- `mem_busy` is combinational from state, `ex_to_mem`, `dmem_req_ready` and `dmem_resp_valid`. There is no combinational path from `dmem_resp_rdata` to `mem_busy`.
- Back-to-back loads: the second request is issued in the cycle after the first response.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - An access with `alu_result[1:0] != 0` issues no request and completes in 1 cycle.
  - `mem_to_wb.reg_write` = 0.
  - `misalign` pulses for 1 cycle (registered), and `misalign_addr` holds the address.
- Undefined:
  - The address is passed unmodified and the memory decides.
  - The `misalign` ports are absent.

## Structure
- The shared package (`riscv_structures.sv`) holds `mem_to_wb_s` and the FSM state enum `mem_state_e`. `ex_to_mem_s` is unchanged.
- No sub-module: the FSM, request mux and output register live in one module.

## Test plan
- ADD result 0x0000_0010, rd = 5, reg_write → next cycle `mem_to_wb` = {reg_write 1, rd 5, result 0x10}; `mem_busy` never high.
- Store addr 0x100, data 0xDEAD_BEEF, ready = 1 → request seen with we = 1 in 1 cycle; `mem_to_wb.reg_write` = 0; busy 0.
- Load addr 0x200, ready = 1, response 0x1234_5678 one cycle later:
  - busy is high for 1 cycle.
  - `mem_to_wb.result` = 0x1234_5678 and rd is correct.
- Load with ready low for 3 cycles, then resp 2 cycles after accept:
  - busy is high for 5 cycles.
  - addr stays stable while valid.
  - exactly one request is issued.
- Reset asserted in WAIT_RESP, then a late `dmem_resp_valid` → state IDLE, outputs 0, response ignored.
- With `MEM_MISALIGN_CHECK_EN`, load addr 0x202 → no `dmem_req_valid`, `misalign` = 1 with addr 0x202, `reg_write` = 0.
